whac_a_mole_engine: RTL and testbench
=====================================

Name: whac_a_mole_engine

Overview:
Parametrised game core for the whack-a-mole board. It supports NUM_HOLES holes and up to MAX_MOLES concurrent moles, each with its own countdown timer. It also tracks lives, a level table for mole count and lifetime, and a saturating streak multiplier. It sits between the RNG (valid/ready hole index), the tick generator, the board switches and LEDs, and the score/lives display drivers.

Parameters:
NUM_HOLES, 18, number of switch/LED holes
MAX_MOLES, 4, number of mole slots; level 3 uses all of them
LIVES, 3, lives at game start
SCORE_W, 16, score width
TICK_W, 12, per-mole countdown width (tick units)
LVL1_TICKS / LVL2_TICKS / LVL3_TICKS, 1500 / 1000 / 600, mole lifetime per level
STREAK_STEP, 10, consecutive hits per multiplier doubling
MULT_MAX, 8, multiplier ceiling (power of two)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick  in  1  one-cycle timebase strobe (1 ms)
start  in  1  level-sensitive start request; rising edge is detected internally
level  in  2  1..3 selects level; 0 means start is ignored
abort  in  1  rising edge returns to IDLE from any state
switches  in  NUM_HOLES  synchronised toggle switches, one per hole
rng_valid  in  1  rng_hole is valid
rng_hole  in  $clog2(NUM_HOLES)  candidate hole index
rng_ready  out  1  engine accepts rng_hole this cycle
mole_mask  out  NUM_HOLES  lit holes (drives LEDs)
score  out  SCORE_W  current score
lives_left  out  $clog2(LIVES+1)  remaining lives
multiplier  out  $clog2(MULT_MAX)+1  current multiplier
game_over  out  1  high in OVER
busy  out  1  high in PLAY

Behaviour:
- Reset values: state IDLE, all slots empty, mole_mask 0, score 0, lives_left LIVES, multiplier 1, streak 0, outputs low.
- States and transitions:
  - IDLE: on a start rising edge with level != 0, latch level, target = {1, 2, MAX_MOLES}[level], lifetime = LVLn_TICKS; clear score, streak and slots; set lives_left = LIVES, multiplier = 1; go to PLAY.
  - PLAY: the spawn, hit and timeout rules below apply. lives_left reaching 0 moves to OVER on the next cycle, and all slots clear.
  - OVER: score holds, mole_mask = 0; waits for abort, or a start edge which acts as in IDLE.
  - abort rising edge in any state: go to IDLE next cycle and clear slots; score holds until the next start.
- Spawn:
  - rng_ready = 1 only in PLAY with active slot count < target.
  - When rng_valid & rng_ready, the hole is accepted into the lowest free slot, countdown = lifetime, and it appears in mole_mask on the next cycle.
  - A handshake whose hole is >= NUM_HOLES or already lit is consumed and discarded; nothing is spawned.
  - At most one spawn per cycle.
- Hit:
  - A switch toggle (either edge, registered previous value) on a lit hole clears that slot.
  - score += multiplier, saturating at all-ones; streak++.
  - When streak reaches a nonzero multiple of STREAK_STEP, multiplier doubles, saturating at MULT_MAX.
  - Multiple hits in one cycle each count, all at the pre-cycle multiplier, and the doubling check runs once.
- Wrong whack: a toggle on an unlit hole resets streak to 0 and multiplier to 1. No life is lost and score is unchanged.
- Timeout:
  - Each occupied slot decrements on tick; it expires when it decrements from 1 to 0.
  - Expiry clears the slot, lives_left--, and resets streak and multiplier.
  - Several expiries in the same cycle each cost a life; lives_left floors at 0.
- Simultaneous events:
  - Hit and expiry of the same slot in one cycle: the hit wins and no life is lost.
  - Hit and spawn in one cycle: the freed slot is not reusable until the next cycle.
  - A wrong whack and a hit in the same cycle: the hit scores first, then the streak and multiplier reset.
- mole_mask is registered, with no combinational path from switches.

Decomposition:
- Package whac_pkg holds:
  - the game_state_t enum (IDLE, PLAY, OVER);
  - the level_t enum;
  - the level_lifetime() and level_target() functions;
  - the SLOT_IDX_W localparam.
- Sub-module mole_slot is instantiated MAX_MOLES times. It holds the valid bit, hole index and countdown, with load/clear/tick inputs and expired/hit outputs.
- The top level holds the FSM, slot allocator, scoring and lives logic.

Test Plan:
- Start with level=1, rng supplies hole 5; toggle switch 5 after 3 ticks -> mole_mask bit 5 set then cleared, score=1, streak=1, lives_left=3.
- Level 1, no hits, lifetime forced to 4 ticks, rng keeps offering holes -> life lost every 4 ticks; after the third expiry game_over=1 and mole_mask=0, with score held.
- Level 3 with 10 consecutive hits -> multiplier 2 after the 10th hit; 11th hit adds 2 so score=12; reaching 30 hits gives MULT_MAX saturation check at 8; a wrong whack then sets multiplier=1.
- rng offers an already-lit hole, then hole 20 (>= NUM_HOLES) -> both handshakes consumed, no new mole, active count unchanged.
- Toggle a hole on the same cycle its countdown hits 0 -> score increments and lives_left unchanged.
- Assert rst mid-PLAY with 3 moles lit -> outputs return to reset values immediately; abort edge mid-PLAY -> IDLE next cycle, slots cleared, score held.

Source files
------------

// File: rtl/whac_a_mole_engine_pkg.sv
// Shared types and level-table helpers for the whack-a-mole engine.
package whac_pkg;

  // Width of slot counts (active moles, spawn target); covers up to 15 slots.
  localparam int SLOT_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_1    = 2'd1,
    LVL_2    = 2'd2,
    LVL_3    = 2'd3
  } level_t;

  // Mole lifetime in ticks for the selected level.
  function automatic int level_lifetime(input level_t lvl, input int t1,
                                        input int t2, input int t3);
    int r;
    r = 0;
    case (lvl)
      LVL_1:   r = t1;
      LVL_2:   r = t2;
      LVL_3:   r = t3;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Number of concurrent moles the level tries to keep on the board.
  function automatic logic [SLOT_IDX_W-1:0] level_target(input level_t lvl,
                                                         input int max_moles);
    logic [SLOT_IDX_W-1:0] r;
    r = '0;
    case (lvl)
      LVL_1:   r = SLOT_IDX_W'(1);
      LVL_2:   r = SLOT_IDX_W'(2);
      LVL_3:   r = SLOT_IDX_W'(max_moles);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/whac_a_mole_engine_if.sv
// RNG hole-index handshake between the random source and the engine.
interface whac_a_mole_engine_if #(
  parameter int NUM_HOLES = 18
) ();
  localparam int HOLE_W = $clog2(NUM_HOLES);

  logic              rng_valid;
  logic [HOLE_W-1:0] rng_hole;
  logic              rng_ready;

  modport master (output rng_valid, output rng_hole, input rng_ready);
  modport slave  (input rng_valid, input rng_hole, output rng_ready);
endinterface

// File: rtl/whac_a_mole_engine_mole_slot.sv
// One mole slot: occupancy, hole index and lifetime countdown.
// A hit on the slot's hole beats an expiry in the same cycle.
module mole_slot #(
  parameter int NUM_HOLES = 18,
  parameter int TICK_W    = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         load,
  input  logic [$clog2(NUM_HOLES)-1:0] load_hole,
  input  logic [TICK_W-1:0]            load_ticks,
  input  logic                         tick,
  input  logic [NUM_HOLES-1:0]         toggles,
  output logic                         valid,
  output logic [$clog2(NUM_HOLES)-1:0] hole,
  output logic                         hit,
  output logic                         expired
);
  localparam int HOLE_W = $clog2(NUM_HOLES);

  logic              valid_q, valid_d;
  logic [HOLE_W-1:0] hole_q, hole_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign hit     = valid_q && toggles[hole_q];
  assign expired = valid_q && tick && (cnt_q == TICK_W'(1)) && !hit;
  assign valid   = valid_q;
  assign hole    = hole_q;

  // Next slot contents: clear/hit/expiry free it, load fills an empty slot, tick counts down.
  always_comb begin
    valid_d = valid_q;
    hole_d  = hole_q;
    cnt_d   = cnt_q;
    if (clear || hit || expired) begin
      valid_d = 1'b0;
    end else if (!valid_q && load) begin
      valid_d = 1'b1;
      hole_d  = load_hole;
      cnt_d   = load_ticks;
    end else if (valid_q && tick) begin
      cnt_d = cnt_q - TICK_W'(1);
    end
  end

  // Occupancy flag is the only state that needs a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // Hole index and countdown are only meaningful while the slot is occupied.
  always_ff @(posedge clk) begin
    hole_q <= hole_d;
    cnt_q  <= cnt_d;
  end
endmodule

// File: rtl/whac_a_mole_engine.sv
// Whack-a-mole game core: game FSM, slot allocator, scoring, streak multiplier and lives.
module whac_a_mole_engine
  import whac_pkg::*;
#(
  parameter int NUM_HOLES   = 18,
  parameter int MAX_MOLES   = 4,
  parameter int LIVES       = 3,
  parameter int SCORE_W     = 16,
  parameter int TICK_W      = 12,
  parameter int LVL1_TICKS  = 1500,
  parameter int LVL2_TICKS  = 1000,
  parameter int LVL3_TICKS  = 600,
  parameter int STREAK_STEP = 10,
  parameter int MULT_MAX    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         start,
  input  logic [1:0]                   level,
  input  logic                         abort,
  input  logic [NUM_HOLES-1:0]         switches,
  whac_a_mole_engine_if.slave          rng,
  output logic [NUM_HOLES-1:0]         mole_mask,
  output logic [SCORE_W-1:0]           score,
  output logic [$clog2(LIVES+1)-1:0]   lives_left,
  output logic [$clog2(MULT_MAX):0]    multiplier,
  output logic                         game_over,
  output logic                         busy
);
  localparam int HOLE_W   = $clog2(NUM_HOLES);
  localparam int LIVES_W  = $clog2(LIVES + 1);
  localparam int MULT_W   = $clog2(MULT_MAX) + 1;
  // The streak only matters through the multiplier, so it is kept modulo STREAK_STEP.
  localparam int STREAK_W = $clog2(STREAK_STEP + MAX_MOLES + 1);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  function automatic logic [MULT_W-1:0] mult_double(input logic [MULT_W-1:0] m);
    logic [MULT_W-1:0] r;
    if (m >= MULT_W'(MULT_MAX)) r = MULT_W'(MULT_MAX);
    else                        r = m << 1;
    return r;
  endfunction

  game_state_t             state_q, state_d;
  level_t                  level_q, level_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [LIVES_W-1:0]      lives_q, lives_d;
  logic [MULT_W-1:0]       mult_q, mult_d;
  logic [STREAK_W-1:0]     streak_q, streak_d, streak_sum;
  logic                    start_q, abort_q;
  logic [NUM_HOLES-1:0]    switches_q;

  logic [MAX_MOLES-1:0]    slot_valid, slot_hit, slot_exp, slot_load;
  logic [HOLE_W-1:0]       slot_hole [MAX_MOLES];
  logic                    slot_clr;
  logic [TICK_W-1:0]       lifetime;
  logic [SLOT_IDX_W-1:0]   target, active_cnt, hit_cnt, exp_cnt;
  logic [NUM_HOLES-1:0]    toggles;
  logic                    start_edge, abort_edge, wrong_whack;
  logic                    hole_ok, hole_lit, spawn_ok, found;

  assign start_edge = start && !start_q;
  assign abort_edge = abort && !abort_q;
  assign toggles    = (switches ^ switches_q) & {NUM_HOLES{state_q == ST_PLAY}};
  assign lifetime   = TICK_W'(level_lifetime(level_q, LVL1_TICKS, LVL2_TICKS, LVL3_TICKS));
  assign target     = level_target(level_q, MAX_MOLES);

  assign rng.rng_ready = (state_q == ST_PLAY) && (active_cnt < target);
  assign hole_ok       = int'(rng.rng_hole) < NUM_HOLES;
  assign spawn_ok      = rng.rng_valid && rng.rng_ready && hole_ok && !hole_lit;
  assign wrong_whack   = |(toggles & ~mole_mask);

  for (genvar g = 0; g < MAX_MOLES; g++) begin : g_slot
    mole_slot #(
      .NUM_HOLES (NUM_HOLES),
      .TICK_W    (TICK_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .clear      (slot_clr),
      .load       (slot_load[g]),
      .load_hole  (rng.rng_hole),
      .load_ticks (lifetime),
      .tick       (tick),
      .toggles    (toggles),
      .valid      (slot_valid[g]),
      .hole       (slot_hole[g]),
      .hit        (slot_hit[g]),
      .expired    (slot_exp[g])
    );
  end

  // LED mask straight from slot flops, so switches never reach it combinationally.
  always_comb begin
    mole_mask = '0;
    for (int i = 0; i < MAX_MOLES; i++)
      if (slot_valid[i]) mole_mask[slot_hole[i]] = 1'b1;
  end

  // Is the offered hole already on the board?
  always_comb begin
    hole_lit = 1'b0;
    for (int h = 0; h < NUM_HOLES; h++)
      if (int'(rng.rng_hole) == h) hole_lit = mole_mask[h];
  end

  // Occupancy, hit and expiry counts across all slots.
  always_comb begin
    active_cnt = '0;
    hit_cnt    = '0;
    exp_cnt    = '0;
    for (int i = 0; i < MAX_MOLES; i++) begin
      active_cnt = active_cnt + SLOT_IDX_W'(slot_valid[i]);
      hit_cnt    = hit_cnt + SLOT_IDX_W'(slot_hit[i]);
      exp_cnt    = exp_cnt + SLOT_IDX_W'(slot_exp[i]);
    end
  end

  // Lowest free slot takes an accepted hole; a slot freed this cycle still reads as busy.
  always_comb begin
    slot_load = '0;
    found     = 1'b0;
    for (int i = 0; i < MAX_MOLES; i++) begin
      if (spawn_ok && !found && !slot_valid[i]) begin
        slot_load[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Game FSM next state plus score, streak, multiplier and lives updates.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    score_d    = score_q;
    lives_d    = lives_q;
    mult_d     = mult_q;
    streak_d   = streak_q;
    streak_sum = '0;
    slot_clr   = 1'b0;
    if (abort_edge) begin
      state_d  = ST_IDLE;
      slot_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_edge && (level != 2'd0)) begin
            state_d  = ST_PLAY;
            level_d  = level_t'(level);
            score_d  = '0;
            lives_d  = LIVES_W'(LIVES);
            mult_d   = MULT_W'(1);
            streak_d = '0;
            slot_clr = 1'b1;
          end
        end
        ST_PLAY: begin
          // Every hit this cycle scores at the multiplier held before the cycle.
          if (hit_cnt != '0) begin
            score_d    = sat_add(score_q, SCORE_W'(hit_cnt) * SCORE_W'(mult_q));
            streak_sum = streak_q + STREAK_W'(hit_cnt);
            if (streak_sum >= STREAK_W'(STREAK_STEP)) begin
              streak_d = streak_sum - STREAK_W'(STREAK_STEP);
              mult_d   = mult_double(mult_q);
            end else begin
              streak_d = streak_sum;
            end
          end
          // A miss or an escaped mole breaks the streak after any scoring above.
          if (wrong_whack || (exp_cnt != '0)) begin
            streak_d = '0;
            mult_d   = MULT_W'(1);
          end
          if (exp_cnt != '0)
            lives_d = (int'(exp_cnt) >= int'(lives_q)) ? '0 : lives_q - LIVES_W'(exp_cnt);
          if (lives_d == '0) begin
            state_d  = ST_OVER;
            slot_clr = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Game state registers and input edge detectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      level_q    <= LVL_NONE;
      score_q    <= '0;
      lives_q    <= LIVES_W'(LIVES);
      mult_q     <= MULT_W'(1);
      streak_q   <= '0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      switches_q <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      mult_q     <= mult_d;
      streak_q   <= streak_d;
      start_q    <= start;
      abort_q    <= abort;
      switches_q <= switches;
    end
  end

  assign score      = score_q;
  assign lives_left = lives_q;
  assign multiplier = mult_q;
  assign game_over  = (state_q == ST_OVER);
  assign busy       = (state_q == ST_PLAY);
endmodule

// File: tb/tb_whac_a_mole_engine.sv
// Directed bench for whac_a_mole_engine with hand-computed expectations.
module tb_whac_a_mole_engine;
  localparam int NH = 18;

  logic          clk = 1'b0;
  logic          rst, tick, start, abort;
  logic [1:0]    level;
  logic [NH-1:0] switches;
  logic [NH-1:0] mole_mask;
  logic [15:0]   score;
  logic [1:0]    lives_left;
  logic [3:0]    multiplier;
  logic          game_over, busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  whac_a_mole_engine_if #(.NUM_HOLES(NH)) rng_if ();

  // Level 1 lifetime shortened to 4 ticks so expiries happen quickly.
  whac_a_mole_engine #(
    .NUM_HOLES  (NH),
    .LVL1_TICKS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .level      (level),
    .abort      (abort),
    .switches   (switches),
    .rng        (rng_if),
    .mole_mask  (mole_mask),
    .score      (score),
    .lives_left (lives_left),
    .multiplier (multiplier),
    .game_over  (game_over),
    .busy       (busy)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic spawn(input int h);
    rng_if.rng_valid = 1'b1;
    rng_if.rng_hole  = 5'(h);
    step(1);
    rng_if.rng_valid = 1'b0;
  endtask

  task automatic whack(input int h);
    switches[h] = ~switches[h];
    step(1);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; abort = 1'b0; level = 2'd0;
    switches = '0; rng_if.rng_valid = 1'b0; rng_if.rng_hole = '0;
    step(2);
    chk("rst_mask", mole_mask, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives_left, 3);
    chk("rst_mult", multiplier, 1);
    chk("rst_over", game_over, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", rng_if.rng_ready, 0);
    rst = 1'b0;
    step(1);

    // Start with level 0 is ignored.
    start = 1'b1; level = 2'd0;
    step(1);
    chk("lvl0_busy", busy, 0);
    start = 1'b0;
    step(1);

    // Level 1: one mole on hole 5, hit after three ticks.
    level = 2'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("l1_busy", busy, 1);
    chk("l1_ready", rng_if.rng_ready, 1);
    spawn(5);
    chk("l1_spawn_mask", mole_mask, 32'h20);
    chk("l1_full_ready", rng_if.rng_ready, 0);
    repeat (3) do_tick();
    chk("l1_alive_mask", mole_mask, 32'h20);
    whack(5);
    chk("l1_hit_mask", mole_mask, 0);
    chk("l1_hit_score", score, 1);
    chk("l1_hit_lives", lives_left, 3);
    chk("l1_hit_mult", multiplier, 1);

    // Level 1 timeouts: RNG keeps offering hole 7, no hits.
    rng_if.rng_valid = 1'b1; rng_if.rng_hole = 5'd7;
    step(1);
    chk("to_spawn_mask", mole_mask, 32'h80);
    for (int k = 0; k < 3; k++) begin
      repeat (4) do_tick();
      chk("to_lives", lives_left, 2 - k);
      chk("to_mask", mole_mask, 0);
      if (k < 2) begin
        step(1);
        chk("to_respawn_mask", mole_mask, 32'h80);
      end
    end
    rng_if.rng_valid = 1'b0;
    chk("to_over", game_over, 1);
    chk("to_busy", busy, 0);
    chk("to_score_held", score, 1);
    chk("to_ready", rng_if.rng_ready, 0);

    // Level 3 from OVER: streak multiplier growth and saturation.
    level = 2'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("l3_busy", busy, 1);
    chk("l3_score_clr", score, 0);
    chk("l3_lives", lives_left, 3);
    for (int i = 0; i < 40; i++) begin
      spawn(12 + (i % 4));
      whack(12 + (i % 4));
      if (i == 9) begin
        chk("hit10_mult", multiplier, 2);
        chk("hit10_score", score, 10);
      end
      if (i == 10) chk("hit11_score", score, 12);
      if (i == 19) begin
        chk("hit20_mult", multiplier, 4);
        chk("hit20_score", score, 30);
      end
      if (i == 29) begin
        chk("hit30_mult", multiplier, 8);
        chk("hit30_score", score, 70);
      end
      if (i == 39) begin
        chk("hit40_mult_sat", multiplier, 8);
        chk("hit40_score", score, 150);
      end
    end

    // Already-lit and out-of-range holes are consumed without spawning.
    spawn(1); spawn(2); spawn(3);
    chk("three_mask", mole_mask, 32'hE);
    chk("three_ready", rng_if.rng_ready, 1);
    rng_if.rng_valid = 1'b1; rng_if.rng_hole = 5'd2;
    #1;
    chk("lit_offer_ready", rng_if.rng_ready, 1);
    step(1);
    chk("lit_mask", mole_mask, 32'hE);
    chk("lit_ready", rng_if.rng_ready, 1);
    rng_if.rng_hole = 5'd20;
    step(1);
    chk("oor_mask", mole_mask, 32'hE);
    chk("oor_ready", rng_if.rng_ready, 1);
    rng_if.rng_hole = 5'd10;
    step(1);
    rng_if.rng_valid = 1'b0;
    chk("fourth_mask", mole_mask, 32'h40E);
    chk("fourth_ready", rng_if.rng_ready, 0);

    // Wrong whack on unlit hole 0.
    whack(0);
    chk("wrong_mult", multiplier, 1);
    chk("wrong_score", score, 150);
    chk("wrong_lives", lives_left, 3);
    chk("wrong_mask", mole_mask, 32'h40E);

    // Three hits in one cycle.
    switches[2] = ~switches[2]; switches[3] = ~switches[3]; switches[10] = ~switches[10];
    step(1);
    chk("multi_score", score, 153);
    chk("multi_mask", mole_mask, 32'h2);

    // Hit on the same cycle the countdown reaches zero.
    repeat (599) do_tick();
    chk("edge_alive_mask", mole_mask, 32'h2);
    tick = 1'b1; switches[1] = ~switches[1];
    step(1);
    tick = 1'b0;
    chk("edge_score", score, 154);
    chk("edge_lives", lives_left, 3);
    chk("edge_mask", mole_mask, 0);
    chk("edge_busy", busy, 1);

    // Asynchronous reset with three moles lit.
    spawn(4); spawn(5); spawn(6);
    chk("pre_rst_mask", mole_mask, 32'h70);
    rst = 1'b1;
    #1;
    chk("arst_mask", mole_mask, 0);
    chk("arst_score", score, 0);
    chk("arst_lives", lives_left, 3);
    chk("arst_mult", multiplier, 1);
    chk("arst_busy", busy, 0);
    chk("arst_over", game_over, 0);
    step(1);
    rst = 1'b0;
    step(1);

    // Abort mid-play returns to IDLE with score held.
    level = 2'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    spawn(9);
    whack(9);
    chk("ab_score", score, 1);
    spawn(11);
    chk("ab_mask", mole_mask, 32'h800);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_over", game_over, 0);
    chk("ab_mask_clr", mole_mask, 0);
    chk("ab_score_held", score, 1);
    chk("ab_ready", rng_if.rng_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
